// File: rtl/mem_write_queue_pkg.sv
// Shared core types: ALU opcodes, register width and the store-queue entry.
// Store entries carry a full-width address; narrower buses zero-extend.
package mem_write_queue_pkg;

  localparam int REG_WIDTH = 32;
  localparam int ADDR_MAX  = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [REG_WIDTH-1:0] a;
    logic [REG_WIDTH-1:0] b;
    alu_op_e              op;
  } alu_req_t;

  typedef struct packed {
    logic [ADDR_MAX-1:0]  addr;
    logic [REG_WIDTH-1:0] data;
  } wr_entry_t;

  function automatic wr_entry_t mk_entry(
    input logic [ADDR_MAX-1:0]  addr,
    input logic [REG_WIDTH-1:0] data
  );
    wr_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/mem_write_if.sv
// Memory write bus: head entry presented with a valid/ready handshake.
interface mem_write_if
  import mem_write_queue_pkg::*;
#(
  parameter int AW = 16
);

  logic                 valid;
  logic                 ready;
  logic [AW-1:0]        addr;
  logic [REG_WIDTH-1:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );

endinterface

// File: rtl/mem_write_fifo.sv
// Circular entry store with head/tail pointers and an occupancy count.
// Tail-data overwrite supports coalescing decided by the parent.
module mem_write_fifo
  import mem_write_queue_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                i_push,
  input  logic                i_ovwr,
  input  wr_entry_t           i_wr,
  output logic [CW-1:0]       o_count,
  output logic [ADDR_MAX-1:0] o_tail_addr,
  mem_write_if.master         bus
);

  wr_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_last;
  logic          w_pop;
  wr_entry_t     w_head;

  assign w_last = r_tail - PW'(1);
  assign w_head = r_mem[r_head];
  assign w_pop  = bus.valid & bus.ready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)
        r_tail <= r_tail + PW'(1);
      if (w_pop)
        r_head <= r_head + PW'(1);
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the parent never pushes during reset.
  always_ff @(posedge clk_i) begin
    if (i_push)
      r_mem[r_tail] <= i_wr;
    else if (i_ovwr)
      r_mem[w_last].data <= i_wr.data;
  end

  assign o_count     = r_count;
  assign o_tail_addr = r_mem[w_last].addr;

  assign bus.valid = (r_count != '0);
  assign bus.addr  = w_head.addr[AW-1:0];
  assign bus.data  = w_head.data;

  if (AW < ADDR_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^w_head.addr[ADDR_MAX-1:AW];
  end

endmodule

// File: rtl/mem_write_queue.sv
// Store buffer between the ALU and memory: coalesces repeat stores to the
// tail entry and flags stores dropped while full.
module mem_write_queue
  import mem_write_queue_pkg::*;
#(
  parameter int mem_addr_width = 16,
  parameter int depth          = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      w_valid_i,
  input  logic [mem_addr_width-1:0] w_addr_i,
  input  logic [REG_WIDTH-1:0]      w_write_i,
  output logic                      full_o,
  output logic                      idle_o,
  output logic                      overflow_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [mem_addr_width-1:0] m_addr_o,
  output logic [REG_WIDTH-1:0]      m_data_o
);

  localparam int CW = $clog2(depth + 1);

  mem_write_if #(.AW(mem_addr_width)) u_bus ();

  logic [CW-1:0]       w_count;
  logic [ADDR_MAX-1:0] w_tail_addr;
  logic [ADDR_MAX-1:0] w_addr_ext;
  logic                w_store;
  logic                w_match;
  logic                w_full;
  logic                w_coal;
  logic                w_push;
  logic                w_drop;
  wr_entry_t           w_entry;
  logic                r_overflow;

  assign w_addr_ext = ADDR_MAX'(w_addr_i);
  assign w_entry    = mk_entry(w_addr_ext, w_write_i);
  assign w_store    = w_valid_i & ~reset_i;
  assign w_full     = (w_count == CW'(depth));

  // Head entry may be mid-handshake, so merging starts at two entries.
  assign w_match = (w_count >= CW'(2)) &&
                   (w_tail_addr == w_addr_ext);

  assign w_coal = w_store & w_match;
  assign w_push = w_store & ~w_match & ~w_full;
  assign w_drop = w_store & ~w_match & w_full;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_overflow <= 1'b0;
    else if (w_drop)
      r_overflow <= 1'b1;
  end

  assign u_bus.ready = m_ready_i;

  mem_write_fifo #(
    .AW    (mem_addr_width),
    .DEPTH (depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .i_push      (w_push),
    .i_ovwr      (w_coal),
    .i_wr        (w_entry),
    .o_count     (w_count),
    .o_tail_addr (w_tail_addr),
    .bus         (u_bus.master)
  );

  assign full_o     = w_full;
  assign idle_o     = (w_count == '0);
  assign overflow_o = r_overflow;
  assign m_valid_o  = u_bus.valid;
  assign m_addr_o   = u_bus.addr;
  assign m_data_o   = u_bus.data;

endmodule

// File: tb/tb_mem_write_queue.sv
// Directed vector bench for mem_write_queue.
// Each step drives inputs, clocks once and checks the registered outputs.
module tb_mem_write_queue;
  import mem_write_queue_pkg::*;

  typedef struct {
    logic        rst;
    logic        wv;
    logic [15:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        e_mv;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    logic        e_full;
    logic        e_idle;
    logic        e_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        w_valid_i;
  logic [15:0] w_addr_i;
  logic [31:0] w_write_i;
  logic        full_o;
  logic        idle_o;
  logic        overflow_o;

  mem_write_if #(.AW(16)) tb_bus ();

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_write_queue #(
    .mem_addr_width (16),
    .depth          (4)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .w_valid_i  (w_valid_i),
    .w_addr_i   (w_addr_i),
    .w_write_i  (w_write_i),
    .full_o     (full_o),
    .idle_o     (idle_o),
    .overflow_o (overflow_o),
    .m_valid_o  (tb_bus.valid),
    .m_ready_i  (tb_bus.ready),
    .m_addr_o   (tb_bus.addr),
    .m_data_o   (tb_bus.data)
  );

  function automatic vec_t v(
    input logic rst, input logic wv,
    input logic [15:0] a, input logic [31:0] d,
    input logic rdy, input logic mv,
    input logic [15:0] ea, input logic [31:0] ed,
    input logic fu, input logic id, input logic ov
  );
    vec_t t;
    t.rst = rst; t.wv = wv; t.addr = a; t.data = d; t.rdy = rdy;
    t.e_mv = mv; t.e_addr = ea; t.e_data = ed;
    t.e_full = fu; t.e_idle = id; t.e_ovf = ov;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h",
                  nm, idx, got, exp);
  endtask

  task automatic step(input vec_t t, input int idx);
    reset_i      = t.rst;
    w_valid_i    = t.wv;
    w_addr_i     = t.addr;
    w_write_i    = t.data;
    tb_bus.ready = t.rdy;
    @(posedge clk);
    #1;
    chk("m_valid", idx, 32'(tb_bus.valid), 32'(t.e_mv));
    chk("full", idx, 32'(full_o), 32'(t.e_full));
    chk("idle", idx, 32'(idle_o), 32'(t.e_idle));
    chk("overflow", idx, 32'(overflow_o), 32'(t.e_ovf));
    if (t.e_mv) begin
      chk("m_addr", idx, 32'(tb_bus.addr), 32'(t.e_addr));
      chk("m_data", idx, tb_bus.data, t.e_data);
    end
  endtask

  vec_t vecs[$];
  vec_t h;

  initial begin
    reset_i      = 1'b1;
    w_valid_i    = 1'b0;
    w_addr_i     = '0;
    w_write_i    = '0;
    tb_bus.ready = 1'b0;

    //        rst wv addr   data          rdy mv eaddr  edata        fu id ov
    vecs.push_back(v(1,0,16'h0000,32'h0,       0, 0,16'h0000,32'h0,       0,1,0));
    // single store
    vecs.push_back(v(0,1,16'h0010,32'hDEADBEEF,1, 1,16'h0010,32'hDEADBEEF,0,0,0));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 0,16'h0000,32'h0,       0,1,0));
    // fill and overflow
    vecs.push_back(v(0,1,16'h0000,32'hA0,      0, 1,16'h0000,32'hA0,      0,0,0));
    vecs.push_back(v(0,1,16'h0001,32'hA1,      0, 1,16'h0000,32'hA0,      0,0,0));
    vecs.push_back(v(0,1,16'h0002,32'hA2,      0, 1,16'h0000,32'hA0,      0,0,0));
    vecs.push_back(v(0,1,16'h0003,32'hA3,      0, 1,16'h0000,32'hA0,      1,0,0));
    vecs.push_back(v(0,1,16'h0004,32'hA4,      0, 1,16'h0000,32'hA0,      1,0,1));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 1,16'h0001,32'hA1,      0,0,1));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 1,16'h0002,32'hA2,      0,0,1));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 1,16'h0003,32'hA3,      0,0,1));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 0,16'h0000,32'h0,       0,1,1));
    vecs.push_back(v(1,0,16'h0000,32'h0,       0, 0,16'h0000,32'h0,       0,1,0));
    // coalesce into tail
    vecs.push_back(v(0,1,16'h0020,32'h1,       0, 1,16'h0020,32'h1,       0,0,0));
    vecs.push_back(v(0,1,16'h0030,32'h2,       0, 1,16'h0020,32'h1,       0,0,0));
    vecs.push_back(v(0,1,16'h0030,32'h3,       0, 1,16'h0020,32'h1,       0,0,0));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 1,16'h0030,32'h3,       0,0,0));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 0,16'h0000,32'h0,       0,1,0));
    // no coalesce into head
    vecs.push_back(v(0,1,16'h0040,32'h7,       0, 1,16'h0040,32'h7,       0,0,0));
    vecs.push_back(v(0,1,16'h0040,32'h8,       0, 1,16'h0040,32'h7,       0,0,0));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 1,16'h0040,32'h8,       0,0,0));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 0,16'h0000,32'h0,       0,1,0));
    // store plus dequeue at count 2
    vecs.push_back(v(0,1,16'h0050,32'h51,      0, 1,16'h0050,32'h51,      0,0,0));
    vecs.push_back(v(0,1,16'h0051,32'h52,      0, 1,16'h0050,32'h51,      0,0,0));
    vecs.push_back(v(0,1,16'h0052,32'h53,      1, 1,16'h0051,32'h52,      0,0,0));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 1,16'h0052,32'h53,      0,0,0));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 0,16'h0000,32'h0,       0,1,0));
    // full: coalesce still allowed, then store plus dequeue drops
    vecs.push_back(v(0,1,16'h0060,32'h60,      0, 1,16'h0060,32'h60,      0,0,0));
    vecs.push_back(v(0,1,16'h0061,32'h61,      0, 1,16'h0060,32'h60,      0,0,0));
    vecs.push_back(v(0,1,16'h0062,32'h62,      0, 1,16'h0060,32'h60,      0,0,0));
    vecs.push_back(v(0,1,16'h0063,32'h63,      0, 1,16'h0060,32'h60,      1,0,0));
    vecs.push_back(v(0,1,16'h0063,32'hBB,      0, 1,16'h0060,32'h60,      1,0,0));
    vecs.push_back(v(0,1,16'h0064,32'h64,      1, 1,16'h0061,32'h61,      0,0,1));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 1,16'h0062,32'h62,      0,0,1));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 1,16'h0063,32'hBB,      0,0,1));
    vecs.push_back(v(0,0,16'h0000,32'h0,       1, 0,16'h0000,32'h0,       0,1,1));

    @(negedge clk);
    foreach (vecs[i]) step(vecs[i], i);

    // backpressure: three entries, head held through three stalled cycles
    step(v(0,1,16'h0070,32'h70,0, 1,16'h0070,32'h70,0,0,1), 100);
    step(v(0,1,16'h0071,32'h71,0, 1,16'h0070,32'h70,0,0,1), 101);
    step(v(0,1,16'h0072,32'h72,0, 1,16'h0070,32'h70,0,0,1), 102);
    for (int k = 0; k < 3; k++)
      step(v(0,0,16'h0,32'h0,0, 1,16'h0070,32'h70,0,0,1), 103 + k);

    // reset mid-handshake; concurrent store and ready are ignored
    step(v(1,1,16'h0099,32'h99,1, 0,16'h0,32'h0,0,1,0), 110);
    step(v(0,0,16'h0,32'h0,1, 0,16'h0,32'h0,0,1,0), 111);
    step(v(0,1,16'h0080,32'h88,0, 1,16'h0080,32'h88,0,0,0), 112);
    h = v(0,0,16'h0,32'h0,1, 0,16'h0,32'h0,0,1,0);
    step(h, 113);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_write_queue.md
MEM_WRITE_QUEUE -- requirements
Module: mem_write_queue

Interface
REQ-001 SHALL have parameter mem_addr_width, default 16, memory address width in bits.
REQ-002 SHALL have parameter depth, default 4, number of queue entries; a power of two and at least 2.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port w_valid_i, input, 1, store strobe from the ALU; high for one cycle per store.
REQ-006 SHALL have port w_addr_i, input, mem_addr_width, store address.
REQ-007 SHALL have port w_write_i, input, REG_WIDTH (32), store data.
REQ-008 SHALL have port full_o, output, 1, high when count equals depth; used by the control unit to stall stores.
REQ-009 SHALL have port idle_o, output, 1, high when count is 0.
REQ-010 SHALL have port overflow_o, output, 1, sticky flag for a dropped store.
REQ-011 SHALL have port m_valid_o, output, 1, head entry is valid on the memory bus.
REQ-012 SHALL have port m_ready_i, input, 1, memory accepts the head entry.
REQ-013 SHALL have port m_addr_o, output, mem_addr_width, head entry address.
REQ-014 SHALL have port m_data_o, output, REG_WIDTH, head entry data.

Function
REQ-015 SHALL keep a circular FIFO of {addr, data} entries with head pointer, tail pointer and count (0..depth); both pointers wrap modulo depth.
REQ-016 SHALL drive m_valid_o, m_addr_o, m_data_o, full_o and idle_o only from registered state; no combinational path from any input to any output.
REQ-017 SHALL hold m_valid_o equal to (count != 0), with m_addr_o and m_data_o taken from the head entry.
REQ-018 SHALL dequeue on a cycle where m_valid_o and m_ready_i are both high: head advances by 1 and count decrements.
REQ-019 SHALL keep m_addr_o and m_data_o stable while m_valid_o is high and m_ready_i is low.
REQ-020 SHALL coalesce when w_valid_i is high, count >= 2 and w_addr_i equals the tail entry address: the tail data is overwritten with w_write_i and count is unchanged; coalescing is allowed while full.
REQ-021 SHALL never coalesce into the head entry; when count == 1, a store to the same address enqueues as a new entry.
REQ-022 SHALL enqueue when w_valid_i is high, coalescing does not apply and full_o is low (count < depth at the start of the cycle): the entry is written at tail, tail advances and count increments.
REQ-023 SHALL, when full, accept no enqueue even if a dequeue happens in the same cycle.
REQ-024 SHALL, when a store is neither coalesced nor enqueued, drop it and set overflow_o, which stays high until reset.
REQ-025 SHALL, on simultaneous enqueue and dequeue with 0 < count < depth, leave count unchanged and advance both pointers.
REQ-026 SHALL have a latency of one cycle: a store enqueued into an empty queue at edge N shows m_valid_o high after edge N.
REQ-027 SHALL present entries on the bus in enqueue order, with each coalesced entry carrying the newest data.

Reset
REQ-028 SHALL, when reset_i is high at a clock edge, clear count, head, tail and overflow_o, so that m_valid_o=0, full_o=0 and idle_o=1 after that edge.
REQ-029 SHALL discard all entries on reset, including a head entry mid-handshake; entry storage needs no reset, and m_addr_o/m_data_o are don't-care while m_valid_o is low.
REQ-030 SHALL ignore w_valid_i and m_ready_i in any cycle where reset_i is high.

Structure
REQ-031 SHALL take REG_WIDTH and a shared write-entry struct {addr, data} from the shared package that also holds the ALU typedefs.
REQ-032 SHALL place entry storage and pointer logic in one sub-module, mem_write_fifo; coalescing and overflow logic stay in mem_write_queue.

Verification
REQ-033 Single store: empty queue; store addr 0x0010, data 0xDEADBEEF, m_ready_i=1 -> m_valid_o high exactly one cycle with 0x0010/0xDEADBEEF; then idle_o=1.
REQ-034 Fill and overflow: m_ready_i=0; 5 stores to 0x0,0x1,0x2,0x3,0x4 -> full_o=1 after the 4th; the 5th is dropped and overflow_o=1; draining yields 0x0..0x3 in order.
REQ-035 Coalesce: m_ready_i=0; stores (0x20,1), (0x30,2), (0x30,3) -> count=2; drain yields (0x20,1) then (0x30,3).
REQ-036 No head coalesce: m_ready_i=0; stores (0x40,7) then (0x40,8) -> count=2; drain yields both, in order.
REQ-037 Backpressure and simultaneous events: head held stable through 3 cycles of m_ready_i=0; with count=2, store plus dequeue in one cycle keeps count=2; when full, store plus dequeue in one cycle leaves count=3 and sets overflow_o.
REQ-038 Reset mid-operation: count=3 with m_valid_o high and m_ready_i=0; assert reset_i one cycle -> m_valid_o=0, idle_o=1, overflow_o=0; a following store is presented normally.
